// File: rtl/wallace_mul_arbiter.sv
// Shares one combinational 16x16 multiplier among NUM_REQ requesters with a registered response.
// Define MUL_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module wallace_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [15:0]            mul_number0,
  output logic [15:0]            mul_number1,
  input  logic [31:0]            mul_q,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_q
);

  typedef enum logic [1:0] {StIdle, StMul, StHold} state_e;

  state_e          r_state, w_state_d;
  logic [ID_W-1:0] r_last, r_id, r_rsp_id;
  logic [15:0]     r_mul_a, r_mul_b;
  logic [31:0]     r_rsp_q;
  logic            r_rsp_valid;
  logic [ID_W-1:0] w_grant;
  logic            w_can_grant, w_fire;

  assign w_can_grant = (r_state == StIdle) | ((r_state == StHold) & rsp_ready);
  assign w_fire      = w_can_grant & (|req_valid);

  // Scan from lowest priority to highest so the final assignment is the winner.
  always_comb begin
    w_grant = '0;
`ifdef MUL_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_grant = ID_W'(i);
    end
`else
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      if (req_valid[(32'(r_last) + off) % NUM_REQ]) begin
        w_grant = ID_W'((32'(r_last) + off) % NUM_REQ);
      end
    end
`endif
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_fire) w_state_d = StMul;
      StMul:   w_state_d = StHold;
      StHold:  if (rsp_ready) w_state_d = w_fire ? StMul : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (w_fire) req_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_id        <= '0;
      r_last      <= ID_W'(NUM_REQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
    end else begin
      if (w_fire) begin
        r_mul_a <= req_a[16*w_grant +: 16];
        r_mul_b <= req_b[16*w_grant +: 16];
        r_id    <= w_grant;
        r_last  <= w_grant;
      end
      if (r_state == StMul) begin
        r_rsp_q     <= mul_q;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == StHold) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign mul_number0 = r_mul_a;
  assign mul_number1 = r_mul_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_q       = r_rsp_q;

endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational `wallace_mul` 16x16 unsigned multiplier among NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands onto the multiplier inputs and captures the 32-bit product one cycle later. It returns the product and the requester index on a single response channel with backpressure. It sits between the operand sources (test/stimulus logic or datapath clients) and the `wallace_mul` instance.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: response index width; 2**ID_W >= NUM_REQ.

Ports:
- sys_clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset; also drives the multiplier's rst_n.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero; combinational.
- req_a  in  16*NUM_REQ  operand A; requester i uses bits [16i+15:16i].
- req_b  in  16*NUM_REQ  operand B; same packing as req_a.
- mul_number0  out  16  to multiplier number0 (operand A); registered.
- mul_number1  out  16  to multiplier number1 (operand B); registered.
- mul_q  in  32  multiplier product (combinational from mul_number0/1).
- rsp_valid  out  1  response valid; registered.
- rsp_ready  in  1  response consumer accept.
- rsp_id  out  ID_W  index of the requester that produced rsp_q.
- rsp_q  out  32  product, unsigned.

## Operation
- FSM states: IDLE, MUL, HOLD. Reset state is IDLE.
- can_grant = (state==IDLE) | (state==HOLD & rsp_ready).
- g = the arbitration winner among req_valid; req_ready[g] = can_grant & (|req_valid); all other req_ready bits are 0.
- A handshake occurs when req_valid[g] & req_ready[g] at an edge. On that edge:
  - mul_number0 <= A[g] and mul_number1 <= B[g].
  - id_reg <= g.
  - last <= g.
  - state <= MUL.
- MUL, unconditional on the next edge:
  - rsp_q <= mul_q.
  - rsp_id <= id_reg.
  - rsp_valid <= 1.
  - state <= HOLD.
- HOLD: rsp_valid, rsp_q and rsp_id hold stable while rsp_ready = 0. On an edge with rsp_ready = 1:
  - if a grant occurs in the same cycle, rsp_valid <= 0 and state <= MUL (back-to-back operation);
  - otherwise rsp_valid <= 0 and state <= IDLE.
- Round-robin: the search starts at (last+1) mod NUM_REQ and picks the first asserted req_valid. last resets to NUM_REQ-1, so requester 0 wins first.
- mul_number0/1 hold their last value when no grant occurs.
- Arithmetic: the full 32-bit unsigned product with no truncation. 0*x = 0. 65535*65535 = 0xFFFE0001.
- Requesters must hold req_a, req_b and req_valid until accepted. The block never accepts two requests in one cycle.

## Timing
- Reset values: req_ready = 0, mul_number0 = 0, mul_number1 = 0, rsp_valid = 0, rsp_id = 0, rsp_q = 0, last = NUM_REQ-1, state = IDLE.
- Latency: request accepted at edge k; rsp_valid = 1 after edge k+1.
- Maximum throughput: one result every 2 cycles, with rsp_ready held high and requests pending.
- rsp_ready = 0 stalls all grants; no request is lost or reordered.
- Reset mid-operation (any state): in-flight results are discarded, all outputs return to reset values immediately, and arbitration restarts from requester 0.
- req_valid deasserting while not granted is a protocol violation. The block does not need to detect it.

## Configuration
- MUL_ARB_FIXED_PRIO_EN defined: fixed priority, where the lowest asserted index always wins. last is still maintained but ignored.
- MUL_ARB_FIXED_PRIO_EN undefined (default): round-robin as in Operation.

## Test plan
- Single request on requester 0: A = 11451, B = 250, rsp_ready = 1. Required: req_ready[0] in the first cycle; rsp_valid two edges later with rsp_q = 2862750 and rsp_id = 0.
- Requester 2: A = 32000, B = 11, followed by A = 65535, B = 65535. Required: rsp_q = 352000, then 0xFFFE0001, both with rsp_id = 2. A = 0, B = 850 gives rsp_q = 0.
- All four requesters valid continuously, rsp_ready = 1. Required: grants in order 0,1,2,3,0; one rsp_valid every 2 cycles. Define MUL_ARB_FIXED_PRIO_EN: grants 0,0,0 while req 0 is held valid.
- Backpressure: rsp_ready = 0 for 5 cycles while responding with A = 1664, B = 2615. Required: rsp_q = 4351360 held stable and req_ready = 0 throughout; on rsp_ready = 1, the next grant happens in the same cycle.
- Reset asserted in MUL with A = 10086, B = 12306 in flight. Required: all outputs are 0 immediately and no response appears after reset release. The first post-reset grant goes to the lowest valid requester.
